pwm_fade_array: RTL

Multi-channel PWM LED fader. It is the parametrised successor to the single-pattern three-LED fader. It drives CHANNELS LED outputs from one free-running PWM counter. Each channel has its own brightness and direction registers, stepped on a shared tick divider. Run-time modes give off, synchronous fade, phase-staggered fade and hold. Brightness arithmetic saturates cleanly at both ends, and output polarity is selectable. The block sits directly between the board clock and the LED pins.

---
 rtl/pwm_fade_array.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pwm_fade_array.sv
// Multi-channel PWM LED fader: one shared PWM counter, per-channel saturating
// brightness ramps stepped by a shared tick divider, selectable output polarity.
module pwm_fade_array #(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned PWM_WIDTH  = 8,
    parameter int unsigned STEP       = 5,
    parameter int unsigned TICK_DIV   = 1_500_000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] led,
    output logic                step_tick
);

    localparam int unsigned MAX   = (2 ** PWM_WIDTH) - 1;
    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_FADE    = 2'd1;
    localparam logic [1:0] MODE_STAGGER = 2'd2;
    localparam logic [1:0] MODE_HOLD    = 2'd3;

    localparam logic [PWM_WIDTH:0]   MAX_X  = (PWM_WIDTH + 1)'(MAX);
    localparam logic [PWM_WIDTH:0]   STEP_X = (PWM_WIDTH + 1)'(STEP);
    localparam logic [PWM_WIDTH-1:0] MAX_W  = PWM_WIDTH'(MAX);
    localparam logic [PWM_WIDTH-1:0] STEP_W = PWM_WIDTH'(STEP);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Evenly spread starting brightness for the staggered pattern.
    function automatic logic [PWM_WIDTH-1:0] stagger_init(input int unsigned idx);
        return PWM_WIDTH'((idx * MAX) / CHANNELS);
    endfunction

    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [PWM_WIDTH-1:0] b_q [CHANNELS];
    logic [PWM_WIDTH-1:0] b_d [CHANNELS];
    logic [CHANNELS-1:0]  dir_q, dir_d;
    logic [1:0]           mode_q, mode_d;
    logic [CHANNELS-1:0]  led_q, led_d;
    logic                 step_tick_q, step_tick_d;
    logic                 wrap_c;

    assign wrap_c = (div_cnt_q == DIV_LAST);

    // Next-state: mode load takes priority over the tick-driven brightness step.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_WIDTH'(1);
        div_cnt_d   = wrap_c ? '0 : div_cnt_q + DIV_W'(1);
        mode_d      = mode_q;
        b_d         = b_q;
        dir_d       = dir_q;
        step_tick_d = 1'b0;

        if (mode != mode_q) begin
            mode_d    = mode;
            div_cnt_d = '0;
            case (mode)
                MODE_OFF, MODE_FADE: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) b_d[i] = '0;
                    dir_d = '1;
                end
                MODE_STAGGER: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) b_d[i] = stagger_init(i);
                    dir_d = '1;
                end
                default: ;
            endcase
        end else if (wrap_c && (mode_q == MODE_FADE || mode_q == MODE_STAGGER)) begin
            step_tick_d = 1'b1;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (dir_q[i]) begin
                    if (({1'b0, b_q[i]} + STEP_X) >= MAX_X) begin
                        b_d[i]   = MAX_W;
                        dir_d[i] = 1'b0;
                    end else begin
                        b_d[i] = b_q[i] + STEP_W;
                    end
                end else begin
                    if ({1'b0, b_q[i]} <= STEP_X) begin
                        b_d[i]   = '0;
                        dir_d[i] = 1'b1;
                    end else begin
                        b_d[i] = b_q[i] - STEP_W;
                    end
                end
            end
        end
    end

    // PWM compare against the current counter and brightness; polarity applied last.
    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            led_d[i] = ((mode_q != MODE_OFF) && (pwm_cnt_q < b_q[i])) ^ ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q   <= '0;
            div_cnt_q   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) b_q[i] <= '0;
            dir_q       <= '1;
            mode_q      <= MODE_OFF;
            led_q       <= {CHANNELS{ACTIVE_LOW}};
            step_tick_q <= 1'b0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            div_cnt_q   <= div_cnt_d;
            b_q         <= b_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
            step_tick_q <= step_tick_d;
        end
    end

    assign led       = led_q;
    assign step_tick = step_tick_q;

endmodule
